// File: rtl/arcsin_arb_pkg.sv
// Shared types and defaults for the two-requester arcsin LUT arbiter.
// Tag ids identify which requester a lookup result belongs to.
package arcsin_arb_pkg;

    localparam int IN_WIDTH_DEF    = 12;
    localparam int OUT_WIDTH_DEF   = 16;
    localparam int LUT_LATENCY_DEF = 1;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/arcsin_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags that tracks lookups through the LUT.
// Advances every cycle; a synchronous reset drops all in-flight tags.
module arcsin_tag_pipe
    import arcsin_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    // Shift tags one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/arcsin_lut_arbiter.sv
// Round-robin sharing of one registered arcsin LUT between requesters A and B.
// Optional ARCSIN_ARB_STATS_EN adds an orphan-result flag and per-requester stall counters.
module arcsin_lut_arbiter
    import arcsin_arb_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int LUT_LATENCY = LUT_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  a_din,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  b_din,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [IN_WIDTH-1:0]  lut_din,
    output logic                 lut_din_valid,
    input  logic [OUT_WIDTH-1:0] lut_dout,
    input  logic                 lut_dout_valid,
    output logic [OUT_WIDTH-1:0] a_dout,
    output logic                 a_dout_valid,
    output logic [OUT_WIDTH-1:0] b_dout,
    output logic                 b_dout_valid
`ifdef ARCSIN_ARB_STATS_EN
    ,
    output logic                 err_orphan,
    output logic [15:0]          stall_cnt_a,
    output logic [15:0]          stall_cnt_b
`endif
);

    logic [IN_WIDTH-1:0]  hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic                 hold_a_full_q, hold_a_full_d, hold_b_full_q, hold_b_full_d;
    logic                 last_grant_q, last_grant_d;
    logic [IN_WIDTH-1:0]  lut_din_q, lut_din_d;
    logic                 lut_din_valid_q, lut_din_valid_d;
    logic                 issue_tag_q, issue_tag_d;
    logic [OUT_WIDTH-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic                 a_dout_valid_q, a_dout_valid_d, b_dout_valid_q, b_dout_valid_d;
    logic                 grant_a_s, grant_b_s;
    tag_t                 tag_in_s, tag_out_s;

    // Round-robin grant from the registered hold state.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (hold_a_full_q && hold_b_full_q) begin
            if (last_grant_q == TAG_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (hold_a_full_q) begin
            grant_a_s = 1'b1;
        end else if (hold_b_full_q) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready = ~hold_a_full_q | grant_a_s;
    assign b_ready = ~hold_b_full_q | grant_b_s;

    // Hold refill/drain and lookup issue; a granted hold may refill in the same cycle.
    always_comb begin
        hold_a_d        = hold_a_q;
        hold_a_full_d   = hold_a_full_q;
        hold_b_d        = hold_b_q;
        hold_b_full_d   = hold_b_full_q;
        last_grant_d    = last_grant_q;
        lut_din_d       = lut_din_q;
        issue_tag_d     = issue_tag_q;
        lut_din_valid_d = grant_a_s | grant_b_s;

        if (a_valid && a_ready) begin
            hold_a_d      = a_din;
            hold_a_full_d = 1'b1;
        end else if (grant_a_s) begin
            hold_a_full_d = 1'b0;
        end else begin
            hold_a_full_d = hold_a_full_q;
        end

        if (b_valid && b_ready) begin
            hold_b_d      = b_din;
            hold_b_full_d = 1'b1;
        end else if (grant_b_s) begin
            hold_b_full_d = 1'b0;
        end else begin
            hold_b_full_d = hold_b_full_q;
        end

        if (grant_a_s) begin
            lut_din_d    = hold_a_q;
            issue_tag_d  = TAG_A;
            last_grant_d = TAG_A;
        end else if (grant_b_s) begin
            lut_din_d    = hold_b_q;
            issue_tag_d  = TAG_B;
            last_grant_d = TAG_B;
        end else begin
            lut_din_d    = lut_din_q;
            issue_tag_d  = issue_tag_q;
            last_grant_d = last_grant_q;
        end
    end

    assign tag_in_s = '{valid: lut_din_valid_q, id: issue_tag_q};

    arcsin_tag_pipe #(
        .DEPTH (LUT_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in_s),
        .tag_o (tag_out_s)
    );

    // Route LUT results to their owner; untagged results are dropped.
    always_comb begin
        a_dout_d       = a_dout_q;
        b_dout_d       = b_dout_q;
        a_dout_valid_d = 1'b0;
        b_dout_valid_d = 1'b0;
        if (lut_dout_valid && tag_out_s.valid) begin
            if (tag_out_s.id == TAG_A) begin
                a_dout_d       = lut_dout;
                a_dout_valid_d = 1'b1;
            end else begin
                b_dout_d       = lut_dout;
                b_dout_valid_d = 1'b1;
            end
        end else begin
            a_dout_valid_d = 1'b0;
            b_dout_valid_d = 1'b0;
        end
    end

    // State registers; B is marked last so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_a_q        <= '0;
            hold_a_full_q   <= 1'b0;
            hold_b_q        <= '0;
            hold_b_full_q   <= 1'b0;
            last_grant_q    <= TAG_B;
            lut_din_q       <= '0;
            lut_din_valid_q <= 1'b0;
            issue_tag_q     <= TAG_A;
            a_dout_q        <= '0;
            a_dout_valid_q  <= 1'b0;
            b_dout_q        <= '0;
            b_dout_valid_q  <= 1'b0;
        end else begin
            hold_a_q        <= hold_a_d;
            hold_a_full_q   <= hold_a_full_d;
            hold_b_q        <= hold_b_d;
            hold_b_full_q   <= hold_b_full_d;
            last_grant_q    <= last_grant_d;
            lut_din_q       <= lut_din_d;
            lut_din_valid_q <= lut_din_valid_d;
            issue_tag_q     <= issue_tag_d;
            a_dout_q        <= a_dout_d;
            a_dout_valid_q  <= a_dout_valid_d;
            b_dout_q        <= b_dout_d;
            b_dout_valid_q  <= b_dout_valid_d;
        end
    end

    assign lut_din       = lut_din_q;
    assign lut_din_valid = lut_din_valid_q;
    assign a_dout        = a_dout_q;
    assign a_dout_valid  = a_dout_valid_q;
    assign b_dout        = b_dout_q;
    assign b_dout_valid  = b_dout_valid_q;

`ifdef ARCSIN_ARB_STATS_EN
    logic        err_orphan_q;
    logic [15:0] stall_cnt_a_q, stall_cnt_b_q;

    // Sticky orphan flag and saturating counts of full-but-not-granted cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan_q  <= 1'b0;
            stall_cnt_a_q <= 16'd0;
            stall_cnt_b_q <= 16'd0;
        end else begin
            if (lut_dout_valid && !tag_out_s.valid) begin
                err_orphan_q <= 1'b1;
            end
            if (hold_a_full_q && !grant_a_s) begin
                stall_cnt_a_q <= sat_inc16(stall_cnt_a_q);
            end
            if (hold_b_full_q && !grant_b_s) begin
                stall_cnt_b_q <= sat_inc16(stall_cnt_b_q);
            end
        end
    end

    assign err_orphan  = err_orphan_q;
    assign stall_cnt_a = stall_cnt_a_q;
    assign stall_cnt_b = stall_cnt_b_q;
`endif

endmodule

// File: doc/arcsin_lut_arbiter.md
Name: arcsin_lut_arbiter

Overview:
- Shares one arcsin LUT (1-cycle registered ROM, 12-bit address, 16-bit result) between two angle requesters, A and B, in the DoA pipeline, e.g. two baseline pairs.
- Each requester has a one-entry holding register.
- A round-robin grant issues at most one lookup per cycle.
- A tag pipeline, matched to the LUT latency, routes each result back to the requester that issued it.

Parameters:
- IN_WIDTH, 12, LUT address / requester operand width.
- OUT_WIDTH, 16, LUT result width.
- LUT_LATENCY, 1, cycles from lut_din_valid to lut_dout_valid; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_din  in  IN_WIDTH  requester A operand.
- a_valid  in  1  A operand valid.
- a_ready  out  1  A holding register can accept this cycle.
- b_din  in  IN_WIDTH  requester B operand.
- b_valid  in  1  B operand valid.
- b_ready  out  1  B holding register can accept this cycle.
- lut_din  out  IN_WIDTH  address to shared LUT.
- lut_din_valid  out  1  lookup issue strobe.
- lut_dout  in  OUT_WIDTH  LUT result.
- lut_dout_valid  in  1  LUT result valid.
- a_dout  out  OUT_WIDTH  result for A.
- a_dout_valid  out  1  A result strobe.
- b_dout  out  OUT_WIDTH  result for B.
- b_dout_valid  out  1  B result strobe.

Behaviour:
- Reset (rst=1 at a clk edge):
  - hold_a/hold_b are emptied and the tag pipeline is cleared.
  - last_grant is set to B, so A wins the first tie.
  - All *_dout_valid and lut_din_valid are 0; dout registers and lut_din are 0.
- Input handshake: a transfer occurs when x_valid & x_ready.
  - x_ready = ~hold_x_full | grant_x, combinational from registered state.
  - A requester with a continuous stream and no contention gets full throughput.
- Grant, combinational, from registered holds:
  - Only one hold full: grant it.
  - Both full: grant the requester opposite last_grant.
  - last_grant updates only on a grant.
- Issue: on a grant cycle, lut_din and lut_din_valid are registered from the winning hold.
  - The tag (0=A, 1=B) enters the tag pipeline.
  - The hold clears unless refilled the same cycle.
- Tag pipeline: LUT_LATENCY-deep shift register of {valid, tag}, advanced every cycle and aligned with lut_dout_valid.
- Return path: when lut_dout_valid & tag_valid, lut_dout is registered into a_dout or b_dout per tag, with a one-cycle strobe.
  - The other requester's dout holds its last value.
- Latency, uncontested: input accept edge → issue +1 → LUT result +LUT_LATENCY → dout_valid +1. Total 2+LUT_LATENCY edges (3 at default).
- Contention: the loser waits one cycle per competing grant. Throughput is bounded at 1 lookup/cycle total; with both streaming, each requester gets an alternating half.
- lut_dout_valid with no matching tag_valid (spurious, or in flight across reset): result dropped, no output strobe.
- Reset mid-operation: in-flight LUT results are discarded, because the tags are cleared.
- No ordering guarantee across requesters; per-requester order is preserved.

Optional Feature:
- Macro ARCSIN_ARB_STATS_EN.
- Defined:
  - Adds outputs err_orphan (1 bit, sticky, set on a dropped lut_dout_valid).
  - Adds stall_cnt_a and stall_cnt_b (16 bits each, saturating; count cycles where hold full & not granted).
  - All cleared by rst.
- Undefined: these ports and their logic are absent, and dropped results are silent.

Decomposition:
- Package arcsin_arb_pkg holds:
  - localparam TAG_A=1'b0, TAG_B=1'b1;
  - tag_t struct {valid, id};
  - default widths.
- One natural sub-module: arcsin_tag_pipe (parameterised-depth valid+id shift register with sync reset), instantiated once.

Test Plan:
- Single A request, a_din=12'h800, LUT model returns 16'h1234 → a_dout=16'h1234, a_dout_valid exactly 3 cycles after accept; b_dout_valid stays 0.
- A and B valid in the same cycle after reset (a=12'h010, b=12'h020) → issue order A then B on consecutive cycles; a_dout then b_dout valid one cycle apart with correct values.
- Both stream 8 words continuously → grants alternate A,B,A,B; each stream returns all 8 results in order; a_ready/b_ready each toggle as expected.
- Single requester B streams 16 back-to-back words with A idle → b_ready held 1, one issue per cycle, 16 consecutive b_dout_valid.
- Assert rst while 1 lookup is in flight, and force lut_dout_valid 1 cycle later → no dout_valid; with ARCSIN_ARB_STATS_EN, err_orphan=1 after the post-reset orphan.
- Spurious lut_dout_valid with no prior issue → both dout_valid stay 0; outputs unchanged.
